// File: rtl/pc_fetch_stage_if.sv
// Bundle between the instruction fetch stage and its surroundings: the redirect/stall
// controls and the memory read data going in, the fetch address and IF/ID contents coming out.
interface pc_fetch_stage_if;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        align_err;
    logic [31:0] fetch_count;

    modport master (
        output next_pc, redirect, stall, instruction,
        input  pc_out, pc_plus4, ifid_instr, ifid_pc_plus4, ifid_valid, align_err, fetch_count
    );

    modport slave (
        input  next_pc, redirect, stall, instruction,
        output pc_out, pc_plus4, ifid_instr, ifid_pc_plus4, ifid_valid, align_err, fetch_count
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// Instruction fetch stage: program counter, IF/ID pipeline register, one-bubble flush on
// redirect, sticky misaligned-target flag and a fetched-instruction counter.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    // Left at zero in real use; a nonzero value only serves to reach the counter wrap quickly.
    parameter logic [31:0] RESET_COUNT = 32'h0000_0000
) (
    input logic              clk,
    input logic              rst_n,
    pc_fetch_stage_if.slave  bus
);
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;
    logic        align_q, align_d;
    logic [31:0] count_q, count_d;
    logic [31:0] pc_plus4;
    logic        eff_redir;

    assign pc_plus4 = pc_q + 32'd4;

    // A redirect is only honoured when it comes from a real instruction that is not stalled.
    assign eff_redir = bus.redirect & valid_q & ~bus.stall;

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        valid_d = valid_q;
        align_d = align_q;
        count_d = count_q;
        if (bus.stall) begin
            // hold everything
        end else if (eff_redir) begin
            pc_d    = {bus.next_pc[31:2], 2'b00};
            instr_d = 32'h0;
            pcp4_d  = 32'h0;
            valid_d = 1'b0;
            if (bus.next_pc[1:0] != 2'b00) begin
                align_d = 1'b1;
            end
        end else begin
            pc_d    = pc_plus4;
            instr_d = bus.instruction;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pcp4_q  <= 32'h0;
            valid_q <= 1'b0;
            align_q <= 1'b0;
            count_q <= RESET_COUNT;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
            align_q <= align_d;
            count_q <= count_d;
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.pc_plus4      = pc_plus4;
    assign bus.ifid_instr    = instr_q;
    assign bus.ifid_pc_plus4 = pcp4_q;
    assign bus.ifid_valid    = valid_q;
    assign bus.align_err     = align_q;
    assign bus.fetch_count   = count_q;
endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clk.
REQ-004 NextPC  input  32  redirect target from the jump-select mux (j/jal/jr).
REQ-005 Redirect  input  1  from the jump mux resetJump output: 1 = redirect to NextPC requested by the ID-stage instruction.
REQ-006 Stall  input  1  hazard-unit stall: 1 = hold PC and IF/ID.
REQ-007 Instruction  input  32  instruction-memory read data for PCOut, valid in the same cycle (combinational memory).
REQ-008 PCOut  output  32  current fetch address to instruction memory.
REQ-009 PCPlus4  output  32  PCOut+4, combinational; feeds the jump mux and sequential path.
REQ-010 IFID_Instr  output  32  registered fetched instruction.
REQ-011 IFID_PCPlus4  output  32  registered PCPlus4 of the fetched instruction.
REQ-012 IFID_Valid  output  1  1 = the IF/ID contents are a real instruction; 0 = bubble.
REQ-013 AlignErr  output  1  sticky flag: a misaligned redirect target was received.
REQ-014 FetchCount  output  32  number of instructions captured into IF/ID since reset.

Function
REQ-015 PCPlus4 shall equal PCOut+4 modulo 2^32; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-016 Effective redirect (EffRedir) shall be Redirect AND IFID_Valid AND NOT Stall; Redirect during a bubble or a stall is ignored.
REQ-017 Per edge, priority shall be: Stall, then EffRedir, then normal advance.
REQ-018 Stall=1: PCOut, IFID_*, and FetchCount hold; AlignErr may still hold only its current value.
REQ-019 EffRedir=1: PCOut <= {NextPC[31:2],2'b00}; IFID_Instr <= 32'h0; IFID_PCPlus4 <= 32'h0; IFID_Valid <= 0. The wrong-path instruction fetched that cycle is discarded (one-bubble flush).
REQ-020 EffRedir=1 and NextPC[1:0]!=0: AlignErr <= 1, held until reset.
REQ-021 Normal advance: PCOut <= PCPlus4; IFID_Instr <= Instruction; IFID_PCPlus4 <= PCPlus4; IFID_Valid <= 1; FetchCount <= FetchCount+1.
REQ-022 FetchCount shall wrap from 32'hFFFF_FFFF to 0 and shall not increment on stall or flush cycles.
REQ-023 Back-to-back Redirect: the cycle after a flush, IFID_Valid=0, so Redirect is ignored per REQ-016; no double flush.
REQ-024 Redirect with Stall in the same cycle: stall wins; the redirect shall take effect on the first non-stalled edge if Redirect is still asserted.
REQ-025 Total fetch latency: Instruction at PCOut appears on IFID_Instr one rising edge later.

Reset
REQ-026 While Reset=0: PCOut=RESET_PC, IFID_Instr=0, IFID_PCPlus4=0, IFID_Valid=0, AlignErr=0, FetchCount=0.
REQ-027 Reset asserted mid-operation, including during stall or redirect, shall override all inputs asynchronously; the first capture occurs on the first rising edge after Reset returns to 1.

Verification
REQ-028 Reset release, Stall=0, Redirect=0, memory returns 32'h2001_0005 at 0 -> after edge 1, PCOut=4, IFID_Instr=32'h2001_0005, IFID_PCPlus4=4, IFID_Valid=1, FetchCount=1.
REQ-029 Running at PCOut=32'h10, IFID_Valid=1, Redirect=1, NextPC=32'h0000_0040 -> next edge: PCOut=32'h40, IFID_Valid=0, IFID_Instr=0; FetchCount unchanged; Redirect held 1 next cycle -> ignored, PCOut=32'h44.
REQ-030 PCOut=32'h20, Stall=1 for 3 cycles with Redirect=1 -> PCOut stays 32'h20 and IFID holds; on the first edge with Stall=0, PCOut=NextPC.
REQ-031 Redirect to NextPC=32'h0000_0043 -> PCOut=32'h40, AlignErr=1, which stays 1 through 10 further cycles until Reset=0.
REQ-032 PCOut forced near top via redirect to 32'hFFFF_FFFC -> PCPlus4=0, next advance PCOut=0; FetchCount preset near 32'hFFFF_FFFF wraps to 0.
REQ-033 Reset driven low between clock edges while Redirect=1 -> outputs reach REQ-026 values immediately, without waiting for a clock edge.
